// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: requester-side handshake and register-file port signals of regfile_arbiter.
interface regfile_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req0, req1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1, busy;
    logic [DW-1:0] rdata;
    logic [AW-1:0] w_addr, r_addr_a;
    logic [DW-1:0] w_data, r_data_a;
    logic          write_reg;
    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, r_data_a,
        output gnt0, gnt1, ack0, ack1, busy, rdata, w_addr, w_data, write_reg, r_addr_a
    );
    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, r_data_a,
        input  gnt0, gnt1, ack0, ack1, busy, rdata, w_addr, w_data, write_reg, r_addr_a
    );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin two-requester access controller for the register file.
// Defining RF_ARB_CLEAR_ON_RESET_EN adds a post-reset sweep that zeroes registers 1..31.
module regfile_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    regfile_arbiter_if.slave  io_bus
);
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS, S_ACK} state_t;
`ifdef RF_ARB_CLEAR_ON_RESET_EN
    localparam state_t RST_STATE = S_CLEAR;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_t RST_STATE = S_IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif
    state_t        r_state;
    logic          r_last, r_gnt0, r_gnt1, r_ack0, r_ack1, r_busy, r_write_reg;
    logic [AW-1:0] r_w_addr, r_r_addr_a;
    logic [DW-1:0] r_w_data, r_rdata;
    logic          w_any, w_win, w_wr;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    // r_last names the previous winner, so on contention the other requester goes next
    assign w_any   = io_bus.req0 || io_bus.req1;
    assign w_win   = (io_bus.req0 && io_bus.req1) ? !r_last : io_bus.req1;
    assign w_wr    = w_win ? io_bus.wr1 : io_bus.wr0;
    assign w_addr  = w_win ? io_bus.addr1 : io_bus.addr0;
    assign w_wdata = w_win ? io_bus.wdata1 : io_bus.wdata0;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= RST_STATE;
            r_last      <= 1'b1;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_busy      <= RST_BUSY;
            r_write_reg <= 1'b0;
            r_w_addr    <= '0;
            r_r_addr_a  <= '0;
            r_w_data    <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
`ifdef RF_ARB_CLEAR_ON_RESET_EN
                // r_w_addr doubles as the sweep counter, starting from its reset value of 0
                S_CLEAR: if (r_write_reg && &r_w_addr) begin
                    r_write_reg <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end else begin
                    r_write_reg <= 1'b1;
                    r_w_addr    <= r_w_addr + 1'b1;
                    r_w_data    <= '0;
                end
`endif
                S_IDLE: if (w_any) begin
                    r_state     <= S_ACCESS;
                    r_busy      <= 1'b1;
                    r_last      <= w_win;
                    r_gnt0      <= !w_win;
                    r_gnt1      <= w_win;
                    r_write_reg <= w_wr;
                    r_w_addr    <= w_addr;
                    r_r_addr_a  <= w_addr;
                    r_w_data    <= w_wdata;
                end
                S_ACCESS: begin
                    r_state     <= S_ACK;
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_write_reg <= 1'b0;
                    r_ack0      <= !r_last;
                    r_ack1      <= r_last;
                    if (!r_write_reg) r_rdata <= io_bus.r_data_a;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign io_bus.gnt0      = r_gnt0;
    assign io_bus.gnt1      = r_gnt1;
    assign io_bus.ack0      = r_ack0;
    assign io_bus.ack1      = r_ack1;
    assign io_bus.busy      = r_busy;
    assign io_bus.rdata     = r_rdata;
    assign io_bus.w_addr    = r_w_addr;
    assign io_bus.w_data    = r_w_data;
    assign io_bus.write_reg = r_write_reg;
    assign io_bus.r_addr_a  = r_r_addr_a;
endmodule
